// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply (radix-2 shift-add) / restoring divide unit.
// Define MULDIV_DIV_EN to compile the divide datapath; otherwise every op multiplies.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     mul_sum;
  logic               op_div;
  logic               last_iter;

  assign stall     = busy | start;
  assign last_iter = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_DIV_EN
  logic           op_q;
  logic [WIDTH:0] div_trial;

  assign op_div = op;

  // Operation select latched at start; divide-by-zero flag published with the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == S_IDLE && start) begin
      op_q <= op;
    end else if (last_iter) begin
      div_by_zero <= op_q && (opnd == '0);
    end
  end
`else
  logic op_unused;

  assign op_unused   = op;
  assign op_div      = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_nxt = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    if (op_q) begin
      acc_nxt = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Sequencer: IDLE -> RUN (WIDTH iterations) -> DONE -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            opnd  <= op_div ? b : a;
            acc   <= {{WIDTH{1'b0}}, (op_div ? a : b)};
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            state <= S_DONE;
            done  <= 1'b1;
            hi    <= acc_nxt[2*WIDTH-1:WIDTH];
            lo    <= acc_nxt[WIDTH-1:0];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH = 32); expectations track MULDIV_DIV_EN.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int snap;
  int cyc;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start for the current cycle (cycle 0) and step into cycle 1
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    #1 chk("stall_c0", stall, 1);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
  endtask

  // From cycle 1, wait for done and check latency and results; ends at cycle WIDTH+2
  task automatic finish(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic e_dbz);
    chk({tag, "_busy_c1"}, busy, 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, (cyc < 60), 1);
    chk({tag, "_latency"}, cyc, 33);
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
    chk({tag, "_dbz"}, div_by_zero, e_dbz);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run_check(input string tag, input logic o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] e_hi,
                           input logic [31:0] e_lo, input logic e_dbz);
    issue(o, x, y);
    finish(tag, e_hi, e_lo, e_dbz);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_stall_lo", stall, 0);
    start = 1'b1;
    #1 chk("rst_stall_hi", stall, 1);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_check("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    @(negedge clk);
    run_check("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    run_check("mul_carry", 1'b0, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0);
    @(negedge clk);
`ifdef MULDIV_DIV_EN
    run_check("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    @(negedge clk);
    run_check("div_by_0", 1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    run_check("div_max_16", 1'b1, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0);
`else
    run_check("div_100_7", 1'b1, 32'd100, 32'd7, 32'd0, 32'd700, 1'b0);
    @(negedge clk);
    run_check("div_by_0", 1'b1, 32'h1234, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    run_check("div_max_16", 1'b1, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'hFFFF_FFF0, 1'b0);
`endif

    // Starts at cycle 5 and in the DONE cycle are ignored
    @(negedge clk);
    snap = done_cnt;
    issue(1'b0, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    cyc = 6;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_latency", cyc, 33);
    start = 1'b1; op = 1'b0; a = 32'd11; b = 32'd11;
    chk("ign_lo", lo, 32'd3000);
    chk("ign_hi", hi, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy_c34", busy, 0);
    chk("ign_one_done", done_cnt - snap, 1);

    // Cycle 34 start is accepted
    run_check("accept_c34", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    // Reset at RUN cycle 10 abandons the operation
    @(negedge clk);
    issue(1'b0, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    snap = done_cnt;
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", done_cnt - snap, 0);
    chk("midrst_idle", busy, 0);
    run_check("after_rst", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
